fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter plus instruction register, driven by the 4-phase timing generator's pc_en/ir_en strobes.
//  Sits directly downstream of the generator and upstream of decode/execute.
//  Supplies the instruction-memory address and latches the returned word.
//  Splits the word into opcode and operand and stops fetching on a HALT opcode.
// PARAMETERS
//  ADDR_W    8     PC / memory address width
//  DATA_W    8     instruction word width
//  OPC_W     3     opcode field width: ir[DATA_W-1 -: OPC_W]
//  RESET_PC  0     PC value after reset
//  HALT_OPC  3'b111  opcode that halts fetch
//  CNT_W     16    retired-fetch counter width
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             async, active-high reset
//  pc_en      in   1             PC update strobe from the generator (S0 and S4)
//  ir_en      in   1             IR load strobe from the generator (S2)
//  mem_rdata  in   DATA_W        instruction memory read data for pc_addr
//  mem_rpar   in   1             even-parity bit of mem_rdata; used only with FETCH_PARITY_EN
//  jmp_req    in   1             load jmp_addr on the next pc_en
//  jmp_addr   in   ADDR_W        jump target
//  pc_addr    out  ADDR_W        current PC, registered
//  ir         out  DATA_W        instruction register
//  opcode     out  OPC_W         ir upper field (combinational from ir)
//  operand    out  DATA_W-OPC_W  ir lower field (combinational from ir)
//  ir_valid   out  1             IR holds a fetched word
//  halted     out  1             fetch stopped
//  fetch_cnt  out  CNT_W         number of IR loads since reset
//  par_err    out  1             sticky parity error
// BEHAVIOUR
//  Reset values (async on rst=1):
//  - pc_addr=RESET_PC, ir=0, ir_valid=0, halted=0, fetch_cnt=0, par_err=0
//  - FSM in PRIME
//  FSM states: PRIME, RUN, HALT.
//  PRIME: absorbs the generator's post-reset S0 pc_en strobe.
//  - pc_en: PC unchanged, jmp_req ignored, go to RUN.
//  - ir_en: ignored.
//  RUN, ir_en=1:
//  - ir<=mem_rdata, ir_valid<=1 (stays 1 until rst), fetch_cnt<=fetch_cnt+1 mod 2^CNT_W
//  RUN, pc_en=1:
//  - If ir_valid and opcode==HALT_OPC: go to HALT, PC unchanged.
//  - Else if jmp_req: pc<=jmp_addr.
//  - Else: pc<=pc+1 mod 2^ADDR_W. 0xFF wraps to 0x00 with no flag.
//  Updates take effect on the strobe's clock edge. pc_addr is valid the following cycle (1-cycle latency).
//  jmp_req and jmp_addr are sampled only on a RUN-state pc_en edge. No sticky capture.
//  pc_en and ir_en in the same cycle (RUN):
//  - IR latches mem_rdata for the old PC. PC updates as above.
//  - The HALT check uses the IR value from before the edge.
//  HALT: pc_addr, ir and fetch_cnt frozen; halted=1. pc_en and ir_en ignored. Left only via rst.
//  rst mid-operation: all state returns to reset values immediately, in any state.
// CONFIGURATION
//  Macro FETCH_PARITY_EN.
//  Defined: on a RUN-state ir_en, if ^{mem_rdata,mem_rpar} != 0:
//  - ir not loaded and fetch_cnt not incremented
//  - ir_valid<=0 and par_err<=1 (sticky)
//  - FSM goes to HALT at the same edge
//  Undefined: mem_rpar ignored, par_err tied 0, no parity logic.
// TESTING
//  1. Reset, mem_rdata=0x21 at addr 0, run generator sequence S0,S1,S2,S3,S4 -> PC stays 0 through S0; IR=0x21 after S2; PC=1 after S4; fetch_cnt=1.
//  2. PC=0xFF, pc_en, jmp_req=0 -> PC=0x00.
//  3. jmp_req=1, jmp_addr=0x40 held across an ir_en-only cycle -> PC unchanged. Then pc_en -> PC=0x40.
//  4. IR loaded with 0xE0 (opcode 7), then pc_en -> halted=1, PC frozen. Further strobes change nothing. rst -> PC=RESET_PC, halted=0.
//  5. pc_en and ir_en together with IR=0x05, mem_rdata=0x0A -> IR=0x0A, PC+1, no halt.
//  6. FETCH_PARITY_EN defined, mem_rdata=0x03, mem_rpar=1 on ir_en -> par_err=1, ir_valid=0, halted=1, IR unchanged. Undefined build, same stimulus -> IR=0x03, par_err=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and instruction register for the 4-phase fetch path.
// Optional parity checking of fetched words is enabled by defining FETCH_PARITY_EN.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          OPC_W    = 3,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [OPC_W-1:0]     HALT_OPC = '1,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_en,
    input  logic                    ir_en,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_rpar,
    input  logic                    jmp_req,
    input  logic [ADDR_W-1:0]       jmp_addr,
    output logic [ADDR_W-1:0]       pc_addr,
    output logic [DATA_W-1:0]       ir,
    output logic [OPC_W-1:0]        opcode,
    output logic [DATA_W-OPC_W-1:0] operand,
    output logic                    ir_valid,
    output logic                    halted,
    output logic [CNT_W-1:0]        fetch_cnt,
    output logic                    par_err
);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_ir;
    logic               r_ir_valid;
    logic [CNT_W-1:0]   r_fetch_cnt;
    logic               w_par_hit;
    logic               w_halt_hit;
    logic               w_ir_load;
    logic               w_pc_load;

    // A bad word is rejected on the same strobe that would have loaded it.
`ifdef FETCH_PARITY_EN
    logic r_par_err;
    assign w_par_hit = (r_state == RUN) && ir_en && (^{mem_rdata, mem_rpar});
    assign par_err   = r_par_err;
`else
    logic w_unused_par;
    assign w_unused_par = mem_rpar;
    assign w_par_hit    = 1'b0;
    assign par_err      = 1'b0;
`endif

    // Halt decision looks at the IR contents from before this edge.
    assign w_halt_hit = pc_en && r_ir_valid && (opcode == HALT_OPC);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            PRIME: begin
                if (pc_en) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_par_hit) begin
                    w_state_nxt = HALT;
                end else begin
                    w_ir_load = ir_en;
                    if (w_halt_hit) w_state_nxt = HALT;
                    else            w_pc_load   = pc_en;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = PRIME;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PRIME;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_pc_load) r_pc <= jmp_req ? jmp_addr : r_pc + ADDR_W'(1);
            if (w_ir_load) begin
                r_ir        <= mem_rdata;
                r_ir_valid  <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end else if (w_par_hit) begin
                r_ir_valid  <= 1'b0;
            end
        end
    end

`ifdef FETCH_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_par_err <= 1'b0;
        else if (w_par_hit) r_par_err <= 1'b1;
    end
`endif

    assign pc_addr   = r_pc;
    assign ir        = r_ir;
    assign opcode    = r_ir[DATA_W-1 -: OPC_W];
    assign operand   = r_ir[DATA_W-OPC_W-1:0];
    assign ir_valid  = r_ir_valid;
    assign halted    = (r_state == HALT);
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each strobe cycle pushes the model's expected
// post-edge state, which is popped and compared once the edge has passed.
module tb_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int OPC_W  = 3;
    localparam int CNT_W  = 16;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ir;
        logic              valid;
        logic              halted;
        logic [CNT_W-1:0]  cnt;
        logic              perr;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    pc_en = 1'b0;
    logic                    ir_en = 1'b0;
    logic [DATA_W-1:0]       mem_rdata = '0;
    logic                    mem_rpar = 1'b0;
    logic                    jmp_req = 1'b0;
    logic [ADDR_W-1:0]       jmp_addr = '0;
    logic [ADDR_W-1:0]       pc_addr;
    logic [DATA_W-1:0]       ir;
    logic [OPC_W-1:0]        opcode;
    logic [DATA_W-OPC_W-1:0] operand;
    logic                    ir_valid;
    logic                    halted;
    logic [CNT_W-1:0]        fetch_cnt;
    logic                    par_err;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];
    exp_t m;           // model state
    int   m_state;     // 0 PRIME, 1 RUN, 2 HALT

`ifdef FETCH_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .ir_en(ir_en),
        .mem_rdata(mem_rdata), .mem_rpar(mem_rpar),
        .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .pc_addr(pc_addr), .ir(ir), .opcode(opcode), .operand(operand),
        .ir_valid(ir_valid), .halted(halted), .fetch_cnt(fetch_cnt), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m.pc = '0; m.ir = '0; m.valid = 1'b0; m.halted = 1'b0; m.cnt = '0; m.perr = 1'b0;
        m_state = 0;
    endtask

    task automatic compare_out(input exp_t e);
        logic [OPC_W-1:0]        e_opc;
        logic [DATA_W-OPC_W-1:0] e_opr;
        e_opc = e.ir[DATA_W-1 -: OPC_W];
        e_opr = e.ir[DATA_W-OPC_W-1:0];
        checks++;
        if (pc_addr !== e.pc) begin failures++; $display("FAIL %s pc_addr got=%h exp=%h", e.name, pc_addr, e.pc); end
        checks++;
        if (ir !== e.ir) begin failures++; $display("FAIL %s ir got=%h exp=%h", e.name, ir, e.ir); end
        checks++;
        if (opcode !== e_opc || operand !== e_opr) begin
            failures++; $display("FAIL %s fields got=%h/%h exp=%h/%h", e.name, opcode, operand, e_opc, e_opr);
        end
        checks++;
        if (ir_valid !== e.valid) begin failures++; $display("FAIL %s ir_valid got=%b exp=%b", e.name, ir_valid, e.valid); end
        checks++;
        if (halted !== e.halted) begin failures++; $display("FAIL %s halted got=%b exp=%b", e.name, halted, e.halted); end
        checks++;
        if (fetch_cnt !== e.cnt) begin failures++; $display("FAIL %s fetch_cnt got=%0d exp=%0d", e.name, fetch_cnt, e.cnt); end
        checks++;
        if (par_err !== e.perr) begin failures++; $display("FAIL %s par_err got=%b exp=%b", e.name, par_err, e.perr); end
    endtask

    // One clock cycle of stimulus; expectation derived from the spec model.
    task automatic step(input string name, input bit p, input bit i, input bit jr,
                        input logic [ADDR_W-1:0] ja, input logic [DATA_W-1:0] rd, input bit bad_par);
        exp_t old;
        exp_t e;
        @(negedge clk);
        pc_en = p; ir_en = i; jmp_req = jr; jmp_addr = ja;
        mem_rdata = rd; mem_rpar = (^rd) ^ bad_par;
        old = m;
        if (m_state == 0) begin
            if (p) m_state = 1;
        end else if (m_state == 1) begin
            if (i && PAR_EN && bad_par) begin
                m.valid = 1'b0; m.perr = 1'b1; m_state = 2;
            end else begin
                if (i) begin m.ir = rd; m.valid = 1'b1; m.cnt = m.cnt + 1'b1; end
                if (p) begin
                    if (old.valid && old.ir[DATA_W-1 -: OPC_W] == 3'b111) m_state = 2;
                    else if (jr) m.pc = ja;
                    else m.pc = m.pc + 1'b1;
                end
            end
        end
        m.halted = (m_state == 2);
        e = m;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++; checks++; $display("FAIL %s scoreboard empty", name);
        end else begin
            compare_out(sb_q.pop_front());
        end
        pc_en = 1'b0; ir_en = 1'b0; jmp_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (pc_addr !== 8'h00 || ir !== 8'h00 || ir_valid !== 1'b0 || halted !== 1'b0
            || fetch_cnt !== 16'd0 || par_err !== 1'b0) begin
            failures++;
            $display("FAIL reset got pc=%h ir=%h v=%b h=%b cnt=%0d pe=%b exp pc=00 ir=00 v=0 h=0 cnt=0 pe=0",
                     pc_addr, ir, ir_valid, halted, fetch_cnt, par_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_prime_and_sequence();
        test_reset();
        step("prime_ir_ignored", 0, 1, 0, 8'h00, 8'h99, 0);
        step("s0_prime_jmp_ignored", 1, 0, 1, 8'h77, 8'h21, 0);
        step("s1", 0, 0, 0, 8'h00, 8'h21, 0);
        step("s2_ir_load", 0, 1, 0, 8'h00, 8'h21, 0);
        step("s3", 0, 0, 0, 8'h00, 8'h21, 0);
        step("s4_pc_inc", 1, 0, 0, 8'h00, 8'h21, 0);
    endtask

    task automatic test_jump_hold();
        step("jmp_on_ir_only", 0, 1, 1, 8'h40, 8'h12, 0);
        step("jmp_taken", 1, 0, 1, 8'h40, 8'h12, 0);
        step("jmp_not_sticky", 1, 0, 0, 8'h00, 8'h12, 0);
    endtask

    task automatic test_pc_wrap();
        step("jmp_ff", 1, 0, 1, 8'hFF, 8'h00, 0);
        step("wrap_ff_00", 1, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        step("load_05", 0, 1, 0, 8'h00, 8'h05, 0);
        step("both_0a", 1, 1, 0, 8'h00, 8'h0A, 0);
        // IR still holds 0xE0 only after this edge, so the pc_en here must not halt.
        step("both_e0_no_halt", 1, 1, 0, 8'h00, 8'hE0, 0);
    endtask

    task automatic test_halt();
        step("halt_on_pc_en", 1, 0, 0, 8'h00, 8'h00, 0);
        step("halted_ir_ignored", 0, 1, 0, 8'h00, 8'h3C, 0);
        step("halted_pc_ignored", 1, 0, 1, 8'h55, 8'h3C, 0);
        step("halted_both", 1, 1, 0, 8'h00, 8'h3C, 0);
        test_reset();
        step("post_halt_idle", 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_parity();
        test_reset();
        step("par_prime", 1, 0, 0, 8'h00, 8'h00, 0);
        step("par_good_load", 0, 1, 0, 8'h00, 8'h11, 0);
        step("par_bad_03", 0, 1, 0, 8'h00, 8'h03, 1);
        step("par_after", 1, 1, 0, 8'h00, 8'h22, 0);
    endtask

    task automatic test_random();
        test_reset();
        step("rnd_prime", 1, 0, 0, 8'h00, 8'h00, 0);
        for (int k = 0; k < 40; k++) begin
            logic [DATA_W-1:0] rd;
            rd = 8'($urandom_range(0, 8'hDF));   // opcode never 7: stays in RUN
            step("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), rd, 0);
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        test_prime_and_sequence();
        test_jump_hold();
        test_pc_wrap();
        test_back_to_back();
        test_halt();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

endmodule
